// File: rtl/bcd_convert_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_convert_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'd9;
  localparam logic [3:0] BCD_ADJ_TH  = 4'd5;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/bcd_convert_if.sv
// start/busy/done handshake and result bus of the BCD converter.
interface bcd_convert_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a digit of 5 or more.
module bcd_digit_adjust
  import bcd_convert_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= BCD_ADJ_TH) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bcd_convert.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one result per WIDTH+1 cycles.
// Define BCD_CONVERT_SATURATE_EN to clamp overflowing results to all nines.
module bcd_convert
  import bcd_convert_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  bcd_convert_if.slave  bus
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]   dig_q, dig_d;
  logic            carry_q, carry_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   shifted;
  logic            carry_nx;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (dig_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Top digit's shifted-out bit is dropped from the value but kept as sticky overflow.
  assign shifted  = {adj[BW-2:0], sr_q[WIDTH-1]};
  assign carry_nx = carry_q | adj[BW-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    carry_d = carry_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sr_d    = bus.bin;
          dig_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        sr_d    = sr_q << 1;
        dig_d   = shifted;
        carry_d = carry_nx;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ovf_d   = carry_nx;
`ifdef BCD_CONVERT_SATURATE_EN
          bcd_d   = carry_nx ? {DIGITS{BCD_NINE}} : shifted;
`else
          bcd_d   = shifted;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dig_q   <= '0;
      carry_q <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dig_q   <= dig_d;
      carry_q <= carry_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule
